// File: rtl/audio_frame_sequencer.sv
// Frame sequencer: stream BEATS beats storage->processor, pulse start, wait for a done edge,
// drain BEATS beats processor->reader, repeat per frame. Optional WAIT timeout via SEQ_TIMEOUT_EN.
module audio_frame_sequencer #(
  parameter int unsigned BEATS   = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_frames,
  output logic              data_wr_en,
  output logic [IDX_W-1:0]  input_index,
  output logic [ADDR_W-1:0] storage_read_index,
  output logic              start,
  input  logic              done,
  output logic [IDX_W-1:0]  output_index,
  output logic              reader_wr_en,
  output logic [ADDR_W-1:0] reader_input_index,
  output logic              busy,
  output logic [ADDR_W-1:0] frames_done,
  output logic              seq_done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_NEXT   = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_BEAT  = IDX_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(BEATS);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("audio_frame_sequencer: TIMEOUT must be at least 1");
  end

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  beat_r, beat_s;
  logic [ADDR_W-1:0] in_base_r, in_base_s;
  logic [ADDR_W-1:0] out_base_r, out_base_s;
  logic [ADDR_W-1:0] num_frames_r, num_frames_s;
  logic [ADDR_W-1:0] frames_done_s;
  logic              done_q_r;
  logic              done_edge_s;
  logic              seq_done_s;
  logic              error_s;
  logic              data_wr_en_s, start_s, reader_wr_en_s, busy_s;
  logic [IDX_W-1:0]  input_index_s, output_index_s;
  logic [ADDR_W-1:0] storage_read_index_s, reader_input_index_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] wait_cnt_r, wait_cnt_s;
`endif

  assign done_edge_s = done & ~done_q_r;

  // Next-state, counters and next values of every registered output
  always_comb begin
    state_s       = state_r;
    beat_s        = beat_r;
    in_base_s     = in_base_r;
    out_base_s    = out_base_r;
    num_frames_s  = num_frames_r;
    frames_done_s = frames_done;
    seq_done_s    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    error_s       = error;
    wait_cnt_s    = wait_cnt_r;
`else
    error_s       = 1'b0;
`endif

    // abort outranks go and every state transition; frames_done and error hold
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      beat_s  = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
`ifdef SEQ_TIMEOUT_EN
            error_s = 1'b0;
`endif
            if (num_frames != ADDR_ZERO) begin
              num_frames_s  = num_frames;
              frames_done_s = ADDR_ZERO;
              in_base_s     = ADDR_ZERO;
              out_base_s    = ADDR_ZERO;
              beat_s        = IDX_ZERO;
              state_s       = ST_LOAD;
            end else begin
              seq_done_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (beat_r == LAST_BEAT) begin
            beat_s    = IDX_ZERO;
            in_base_s = in_base_r + FRAME_STEP;
            state_s   = ST_KICK;
          end else begin
            beat_s = beat_r + IDX_ONE;
          end
        end
        ST_KICK: begin
          state_s = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
          wait_cnt_s = TO_ZERO;
`endif
        end
        ST_WAIT: begin
          if (done_edge_s) begin
            beat_s  = IDX_ZERO;
            state_s = ST_UNLOAD;
          end else begin
`ifdef SEQ_TIMEOUT_EN
            if (wait_cnt_r == TO_LAST) begin
              error_s = 1'b1;
              state_s = ST_IDLE;
            end else begin
              wait_cnt_s = wait_cnt_r + TO_ONE;
            end
`else
            state_s = ST_WAIT;
`endif
          end
        end
        ST_UNLOAD: begin
          if (beat_r == LAST_BEAT) begin
            beat_s     = IDX_ZERO;
            out_base_s = out_base_r + FRAME_STEP;
            state_s    = ST_NEXT;
          end else begin
            beat_s = beat_r + IDX_ONE;
          end
        end
        ST_NEXT: begin
          frames_done_s = frames_done + ADDR_ONE;
          if (frames_done_s == num_frames_r) begin
            seq_done_s = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            beat_s  = IDX_ZERO;
            state_s = ST_LOAD;
          end
        end
        default: begin
          state_s = ST_IDLE;
          beat_s  = IDX_ZERO;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    data_wr_en_s         = 1'b0;
    start_s              = 1'b0;
    reader_wr_en_s       = 1'b0;
    input_index_s        = IDX_ZERO;
    output_index_s       = IDX_ZERO;
    storage_read_index_s = ADDR_ZERO;
    reader_input_index_s = ADDR_ZERO;
    busy_s               = (state_s != ST_IDLE);
    case (state_s)
      ST_LOAD: begin
        data_wr_en_s         = 1'b1;
        input_index_s        = beat_s;
        storage_read_index_s = in_base_s + ADDR_W'(beat_s);
      end
      ST_KICK: begin
        start_s = 1'b1;
      end
      ST_UNLOAD: begin
        reader_wr_en_s       = 1'b1;
        output_index_s       = beat_s;
        reader_input_index_s = out_base_s + ADDR_W'(beat_s);
      end
      default: begin
        busy_s = (state_s != ST_IDLE);
      end
    endcase
  end

  // State register, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      beat_r             <= IDX_ZERO;
      in_base_r          <= ADDR_ZERO;
      out_base_r         <= ADDR_ZERO;
      num_frames_r       <= ADDR_ZERO;
      done_q_r           <= 1'b0;
      data_wr_en         <= 1'b0;
      start              <= 1'b0;
      reader_wr_en       <= 1'b0;
      input_index        <= IDX_ZERO;
      output_index       <= IDX_ZERO;
      storage_read_index <= ADDR_ZERO;
      reader_input_index <= ADDR_ZERO;
      busy               <= 1'b0;
      frames_done        <= ADDR_ZERO;
      seq_done           <= 1'b0;
      error              <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_r         <= TO_ZERO;
`endif
    end else begin
      state_r            <= state_s;
      beat_r             <= beat_s;
      in_base_r          <= in_base_s;
      out_base_r         <= out_base_s;
      num_frames_r       <= num_frames_s;
      done_q_r           <= done;
      data_wr_en         <= data_wr_en_s;
      start              <= start_s;
      reader_wr_en       <= reader_wr_en_s;
      input_index        <= input_index_s;
      output_index       <= output_index_s;
      storage_read_index <= storage_read_index_s;
      reader_input_index <= reader_input_index_s;
      busy               <= busy_s;
      frames_done        <= frames_done_s;
      seq_done           <= seq_done_s;
      error              <= error_s;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_r         <= wait_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer: lockstep cycle checks of strobes, indices and
// sequence status, sampled on the falling clock edge.
module tb_audio_frame_sequencer;

  localparam int BEATS = 64;
`ifdef SEQ_TIMEOUT_EN
  localparam int DONE_DLY = 30;
`else
  localparam int DONE_DLY = 99;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        done = 1'b0;
  logic        data_wr_en, start, reader_wr_en, busy, seq_done, error;
  logic [5:0]  input_index, output_index;
  logic [15:0] storage_read_index, reader_input_index, frames_done;

  int vectors = 0;
  int miscompares = 0;

  audio_frame_sequencer #(
    .BEATS(64), .IDX_W(6), .ADDR_W(16), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .num_frames(num_frames),
    .data_wr_en(data_wr_en), .input_index(input_index),
    .storage_read_index(storage_read_index), .start(start), .done(done),
    .output_index(output_index), .reader_wr_en(reader_wr_en),
    .reader_input_index(reader_input_index), .busy(busy),
    .frames_done(frames_done), .seq_done(seq_done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] strb();
    return {29'd0, data_wr_en, start, reader_wr_en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [15:0] n);
    go = 1'b1;
    num_frames = n;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic load_burst(input int base, input int n);
    for (int b = 0; b < n; b++) begin
      chk("load_strobes", strb(), 32'b100);
      chk("input_index", {26'd0, input_index}, 32'(b));
      chk("storage_read_index", {16'd0, storage_read_index}, 32'(base + b));
      @(negedge clk);
    end
  endtask

  task automatic unload_burst(input int base, input int n);
    for (int b = 0; b < n; b++) begin
      chk("unload_strobes", strb(), 32'b001);
      chk("output_index", {26'd0, output_index}, 32'(b));
      chk("reader_input_index", {16'd0, reader_input_index}, 32'(base + b));
      @(negedge clk);
    end
  endtask

  task automatic kick();
    chk("kick_strobes", strb(), 32'b010);
    chk("kick_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("wait_strobes", strb(), 32'b000);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      chk("wait_error", {31'd0, error}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic end_frame(input int f, input bit last);
    chk("next_strobes", strb(), 32'b000);
    chk("next_frames_done", {16'd0, frames_done}, 32'(f));
    @(negedge clk);
    chk("frames_done", {16'd0, frames_done}, 32'(f + 1));
    chk("seq_done", {31'd0, seq_done}, {31'd0, last});
    chk("busy_after_next", {31'd0, busy}, {31'd0, ~last});
    if (last) begin
      @(negedge clk);
      chk("seq_done_single", {31'd0, seq_done}, 32'd0);
    end else begin
      chk("next_load_strobes", strb(), 32'b100);
    end
  endtask

  task automatic run_frame(input int base, input int f, input int dly, input bit last);
    load_burst(base, BEATS);
    done = 1'b0;
    kick();
    wait_idle(dly);
    done = 1'b1;
    @(negedge clk);
    unload_burst(base, BEATS);
    end_frame(f, last);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_strobes", strb(), 32'b000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_seq_done", {31'd0, seq_done}, 32'd0);
    chk("idle_frames_done", {16'd0, frames_done}, 32'd0);

    // Four frames, done 100 cycles after start
    start_seq(16'd4);
    chk("go_busy", {31'd0, busy}, 32'd1);
    chk("go_frames_done", {16'd0, frames_done}, 32'd0);
    run_frame(0, 0, DONE_DLY, 1'b0);
    run_frame(64, 1, DONE_DLY, 1'b0);
    run_frame(128, 2, DONE_DLY, 1'b0);
    run_frame(192, 3, DONE_DLY, 1'b1);
    chk("seq1_busy_low", {31'd0, busy}, 32'd0);

    // Done level left high across frames; also go/num_frames while busy
    done = 1'b0;
    start_seq(16'd2);
    run_frame(0, 0, 5, 1'b0);
    load_burst(64, BEATS);
    kick();
    go = 1'b1;
    num_frames = 16'd1;
    wait_idle(1);
    go = 1'b0;
    wait_idle(19);
    done = 1'b0;
    wait_idle(2);
    done = 1'b1;
    @(negedge clk);
    unload_burst(64, BEATS);
    end_frame(1, 1'b1);

    // Abort at LOAD beat 10 of frame 2
    start_seq(16'd4);
    run_frame(0, 0, 3, 1'b0);
    run_frame(64, 1, 3, 1'b0);
    load_burst(128, 10);
    chk("abort_beat10", {26'd0, input_index}, 32'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_strobes", strb(), 32'b000);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_frames_done", {16'd0, frames_done}, 32'd2);
    chk("abort_seq_done", {31'd0, seq_done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", {28'd0, strb(), seq_done}, 32'd0);
    end
    done = 1'b0;
    start_seq(16'd1);
    chk("restart_frames_done", {16'd0, frames_done}, 32'd0);
    run_frame(0, 0, 4, 1'b1);

    // Zero-frame sequence
    start_seq(16'd0);
    chk("zero_seq_done", {31'd0, seq_done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_strobes", strb(), 32'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_quiet", {28'd0, strb(), seq_done}, 32'd0);
    end

    // Asynchronous reset during UNLOAD
    done = 1'b0;
    start_seq(16'd2);
    load_burst(0, BEATS);
    kick();
    wait_idle(3);
    done = 1'b1;
    @(negedge clk);
    unload_burst(0, 5);
    rst = 1'b1;
    #1;
    chk("arst_strobes", strb(), 32'b000);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_output_index", {26'd0, output_index}, 32'd0);
    chk("arst_reader_index", {16'd0, reader_input_index}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done = 1'b0;
    @(negedge clk);
    start_seq(16'd1);
    run_frame(0, 0, 6, 1'b1);

`ifdef SEQ_TIMEOUT_EN
    // WAIT timeout with done never asserted
    done = 1'b0;
    start_seq(16'd1);
    load_burst(0, BEATS);
    kick();
    wait_idle(50);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_seq_done", {31'd0, seq_done}, 32'd0);
    @(negedge clk);
    chk("timeout_error_sticky", {30'd0, error, seq_done}, 32'b10);
    start_seq(16'd0);
    chk("timeout_error_cleared", {31'd0, error}, 32'd0);
    chk("timeout_next_seq_done", {31'd0, seq_done}, 32'd1);
`else
    chk("error_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
- Frame-level controller for the AudioProcessor datapath; replaces the hand-driven bench sequencing.
- For each frame it streams BEATS 512-bit beats from AudioStorage into the processor, pulses start and waits for done.
- It then drains BEATS beats from the processor into AudioReader, and repeats for a programmed frame count.
- Sits between the host/config logic and the processor/storage/reader trio; it drives indices and strobes only and never touches data.

Parameters:
- BEATS, 64, beats per frame (power of two)
- IDX_W, 6, processor input_index/output_index width, log2(BEATS)
- ADDR_W, 16, storage/reader beat-address width
- TIMEOUT, 65535, max cycles in WAIT before error (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- go  in  1  start sequence; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- num_frames  in  ADDR_W  frames to process; latched on accepted go
- data_wr_en  out  1  processor input write strobe
- input_index  out  IDX_W  processor input beat index
- storage_read_index  out  ADDR_W  AudioStorage beat address; combinational read, data valid same cycle
- start  out  1  one-cycle processor start pulse
- done  in  1  processor done level
- output_index  out  IDX_W  processor output beat index; data_out combinational
- reader_wr_en  out  1  AudioReader write strobe
- reader_input_index  out  ADDR_W  AudioReader beat address
- busy  out  1  high in any state except IDLE
- frames_done  out  ADDR_W  completed frames in current sequence
- seq_done  out  1  one-cycle pulse at sequence end
- error  out  1  sticky timeout flag; cleared by the next accepted go

Behaviour:
- Reset: all outputs 0, state IDLE, base addresses 0.
- States: IDLE, LOAD, KICK, WAIT, UNLOAD, NEXT. All outputs are registered.
- IDLE
  - go=1 and num_frames!=0: latch num_frames, clear frames_done, in_base and out_base; next state LOAD with beat=0.
  - go=1 and num_frames==0: seq_done pulses the next cycle, no other activity.
- LOAD (BEATS cycles)
  - data_wr_en=1, input_index=beat, storage_read_index=in_base+beat.
  - On beat==BEATS-1: go to KICK and add BEATS to in_base.
- KICK (1 cycle): start=1, then WAIT.
- WAIT
  - Waits for a done rising edge (done & ~done_q, done_q registered every cycle).
  - A done level left high from the previous frame does not qualify.
  - On the edge: go to UNLOAD with beat=0.
- UNLOAD (BEATS cycles)
  - reader_wr_en=1, output_index=beat, reader_input_index=out_base+beat.
  - On last beat: add BEATS to out_base and go to NEXT.
- NEXT (1 cycle)
  - frames_done+1.
  - If the new value equals the latched num_frames: go to IDLE and pulse seq_done in the same cycle the state is IDLE.
  - Otherwise go to LOAD.
- Per-frame latency: BEATS + 1 + processor latency + 1 (edge detect) + BEATS + 1 cycles.
- Strobes: no two of data_wr_en, start and reader_wr_en are ever high in the same cycle.
- Addresses: wrap modulo 2^ADDR_W; no error on wrap.
- abort=1 in any non-IDLE state
  - Next cycle: IDLE, all strobes 0. frames_done holds its value; seq_done is not pulsed.
  - abort has priority over go and over every state transition.
- go while busy is ignored; num_frames changes while busy are ignored.
- Asynchronous rst mid-frame forces all outputs to 0 immediately.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT cycles without a done edge: error=1, go to IDLE, no seq_done pulse.
- Undefined:
  - WAIT blocks indefinitely; error is tied to 0.

Test Plan:
- go with num_frames=4, processor done 100 cycles after start
  - -> four LOAD bursts at storage addresses 0-63, 64-127, 128-191, 192-255
  - -> four reader bursts at the same addresses
  - -> frames_done=4, single seq_done pulse, busy low afterward.
- done held high from frame 0 through frame 1's KICK
  - -> frame 1 waits for the next rising edge; no early UNLOAD.
- abort asserted at LOAD beat 10 of frame 2
  - -> next cycle IDLE, all strobes 0, frames_done=2, no seq_done
  - -> a following go with num_frames=1 restarts at address 0.
- go with num_frames=0 -> seq_done 1 cycle later; data_wr_en, start and reader_wr_en never assert.
- rst pulse during UNLOAD -> outputs 0 asynchronously; after release, go with num_frames=1 runs normally from address 0.
- With SEQ_TIMEOUT_EN defined, TIMEOUT=50, done never asserted
  - -> error=1 at WAIT cycle 50, IDLE, no seq_done
  - -> next go clears error.
